// File: rtl/rx_command_sequencer_pkg.sv
// Shared constants for the UART command sequencer: opcodes, FSM state encoding
// and the brightness power-up value.
package rx_command_sequencer_pkg;

  localparam logic [7:0] OPC_ROW_LOAD = 8'h4C;
  localparam logic [7:0] OPC_BRIGHT   = 8'h62;
  localparam logic [7:0] OPC_SWAP     = 8'h52;

  localparam logic [7:0] BRIGHT_RST   = 8'hFF;

  // Encoding is exposed on state_dbg, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ROW_ADDR   = 2'd1,
    ST_ROW_DATA   = 2'd2,
    ST_BRIGHT_VAL = 2'd3
  } state_e;

endpackage

// File: rtl/rx_command_timeout.sv
// Idle-tick counter for an open command: counts while enabled, clears on a
// received byte, and pulses expire when the count reaches TICKS-1.
module rx_command_timeout #(
  parameter int               WIDTH = 22,
  parameter logic [WIDTH-1:0] TICKS = WIDTH'(2272727)
) (
  input  logic clk_in,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAST = TICKS - ONE;

  logic [WIDTH-1:0] count_q, count_d;

  // A byte in the expiry cycle wins: clr suppresses expire.
  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (clr || !en) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      expire  = 1'b1;
      count_d = '0;
    end else begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_command_sequencer.sv
// Parses the UART byte stream into framebuffer row writes, brightness updates
// and frame-swap requests. Optional inter-byte timeout: RX_COMMAND_SEQUENCER_TIMEOUT_EN.
module rx_command_sequencer
  import rx_command_sequencer_pkg::*;
#(
  parameter int                       ROW_ADDR_WIDTH = 4,
  parameter int                       BYTES_PER_ROW  = 128,
  parameter int                       COL_ADDR_WIDTH = 7,
  parameter int                       TIMEOUT_WIDTH  = 22,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS  = 22'd2272727
) (
  input  logic                                     clk_in,
  input  logic                                     reset,
  input  logic [7:0]                               rx_data,
  input  logic                                     rx_data_valid,
  output logic                                     wr_en,
  output logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]                               wr_data,
  output logic [7:0]                               brightness,
  output logic                                     frame_swap,
  output logic                                     row_done,
  output logic                                     cmd_error,
  output logic                                     busy,
  output logic [1:0]                               state_dbg
);

  localparam int AW = ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
  localparam logic [COL_ADDR_WIDTH-1:0] COL_LAST = COL_ADDR_WIDTH'(BYTES_PER_ROW - 1);
  localparam logic [COL_ADDR_WIDTH-1:0] COL_ONE  = COL_ADDR_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [COL_ADDR_WIDTH-1:0] col_q, col_d;
  logic                      wr_en_q, wr_en_d;
  logic [AW-1:0]             wr_addr_q, wr_addr_d;
  logic [7:0]                wr_data_q, wr_data_d;
  logic [7:0]                bright_q, bright_d;
  logic                      swap_q, swap_d;
  logic                      row_done_q, row_done_d;
  logic                      err_q, err_d;
  logic                      timeout_expire;

`ifdef RX_COMMAND_SEQUENCER_TIMEOUT_EN
  rx_command_timeout #(
    .WIDTH (TIMEOUT_WIDTH),
    .TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (state_q != ST_IDLE),
    .clr    (rx_data_valid),
    .expire (timeout_expire)
  );
`else
  logic [TIMEOUT_WIDTH-1:0] timeout_unused;
  assign timeout_unused = TIMEOUT_TICKS;
  assign timeout_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    bright_d   = bright_q;
    swap_d     = 1'b0;
    row_done_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_data_valid) begin
          case (rx_data)
            OPC_ROW_LOAD: state_d = ST_ROW_ADDR;
            OPC_BRIGHT:   state_d = ST_BRIGHT_VAL;
            OPC_SWAP:     swap_d  = 1'b1;
            default:      err_d   = 1'b1;
          endcase
        end
      end
      ST_ROW_ADDR: begin
        if (rx_data_valid) begin
          row_d   = rx_data[ROW_ADDR_WIDTH-1:0];
          col_d   = '0;
          state_d = ST_ROW_DATA;
        end
      end
      ST_ROW_DATA: begin
        if (rx_data_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {row_q, col_q};
          wr_data_d = rx_data;
          // Leaving the row on the last column, so the increment never wraps in use.
          col_d     = col_q + COL_ONE;
          if (col_q == COL_LAST) begin
            row_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_BRIGHT_VAL: begin
        if (rx_data_valid) begin
          bright_d = rx_data;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Expiry only fires in byte-free cycles, so no write is pending here.
    if (timeout_expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      bright_q   <= BRIGHT_RST;
      swap_q     <= 1'b0;
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      bright_q   <= bright_d;
      swap_q     <= swap_d;
      row_done_q <= row_done_d;
      err_q      <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign brightness = bright_q;
  assign frame_swap = swap_q;
  assign row_done   = row_done_q;
  assign cmd_error  = err_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: doc/rx_command_sequencer.md
Name: rx_command_sequencer

Overview:
- Sits between the controller's UART receiver (pin7 byte stream) and the framebuffer write port / display-control registers.
- Parses the byte-oriented command stream into the following operations:
  - framebuffer row writes
  - brightness updates
  - frame-swap requests
- Sole writer of the framebuffer write port. Also supplies the busy indication that the debug path reads.

Parameters:
- ROW_ADDR_WIDTH, 4, row index width; 16 rows, matching ROA0..ROA3.
- BYTES_PER_ROW, 128, data bytes following each row header.
- COL_ADDR_WIDTH, 7, width of byte-within-row counter; must satisfy 2^COL_ADDR_WIDTH >= BYTES_PER_ROW.
- TIMEOUT_TICKS, 22'd2272727, idle clk_in ticks allowed between bytes of an open command.
- TIMEOUT_WIDTH, 22, width of the timeout counter.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_data_valid  in  1  one-cycle strobe; rx_data is valid when high.
- wr_en  out  1  framebuffer write strobe.
- wr_addr  out  ROW_ADDR_WIDTH+COL_ADDR_WIDTH  {row, column} byte address.
- wr_data  out  8  byte to write.
- brightness  out  8  global brightness register.
- frame_swap  out  1  one-cycle pulse requesting a buffer swap.
- row_done  out  1  one-cycle pulse after the last byte of a row is written.
- cmd_error  out  1  one-cycle pulse on an unknown opcode or a timeout abort.
- busy  out  1  high whenever state != IDLE.
- state_dbg  out  2  current state encoding, for debugger readout.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0.
  - brightness=8'hFF.
  - frame_swap=0, row_done=0, cmd_error=0, busy=0.
  - column counter=0, timeout counter=0.
- Reset asserted mid-command discards the partial row. Bytes already written stay in the framebuffer.
- States, encoded in state_dbg: IDLE=0, ROW_ADDR=1, ROW_DATA=2, BRIGHT_VAL=3.
- IDLE, on rx_data_valid, decodes the opcode:
  - 'L' (8'h4C): go to ROW_ADDR.
  - 'b' (8'h62): go to BRIGHT_VAL.
  - 'R' (8'h52): pulse frame_swap next cycle; stay in IDLE.
  - any other byte: pulse cmd_error next cycle; stay in IDLE.
- ROW_ADDR, on valid:
  - latch row = rx_data[ROW_ADDR_WIDTH-1:0]; upper bits are ignored.
  - clear the column counter; go to ROW_DATA.
- ROW_DATA, on valid:
  - the next cycle drives wr_en=1, wr_addr={row,col}, wr_data=rx_data. Latency is exactly 1 cycle from the strobe.
  - col increments after each write.
  - on byte BYTES_PER_ROW-1: row_done pulses in the same cycle as that final wr_en; go to IDLE.
  - col never wraps inside a row.
- BRIGHT_VAL, on valid: brightness<=rx_data (visible next cycle); go to IDLE.
- All pulse outputs are high for exactly one cycle. wr_en is low in every cycle not driven by a ROW_DATA byte.
- Opcode bytes are consumed in IDLE only. Inside ROW_DATA or BRIGHT_VAL, 8'h4C/8'h62/8'h52 are treated as data.
- Back-to-back strobes on consecutive cycles must be accepted without loss.
- busy deasserts in the same cycle the state returns to IDLE.

Optional Feature:
- Macro: RX_COMMAND_SEQUENCER_TIMEOUT_EN.
- Defined:
  - in any non-IDLE state the timeout counter increments every cycle and clears on rx_data_valid.
  - on reaching TIMEOUT_TICKS-1 without a byte: go to IDLE and pulse cmd_error; no wr_en is issued.
  - a byte and expiry in the same cycle: the byte wins and the counter clears.
- Undefined: no timeout counter is instantiated. Only reset or completion leaves a non-IDLE state.

Decomposition:
- Shared package holds:
  - opcode constants OPC_ROW_LOAD=8'h4C, OPC_BRIGHT=8'h62, OPC_SWAP=8'h52.
  - state encoding constants.
  - brightness reset value.
- One sub-module: rx_command_timeout (loadable/clearable tick counter with expiry pulse), instantiated only under the macro.

Test Plan:
- Row load: send 4C, 03, bytes 00..7F ->
  - 128 wr_en pulses with wr_addr 0x180..0x1FF and wr_data 00..7F;
  - row_done coincides with addr 0x1FF;
  - busy falls the same cycle.
- Brightness/swap: send 62, 40, then 52 -> brightness=8'h40 one cycle after the 40 strobe; frame_swap pulses once; no wr_en.
- Unknown opcode then in-row opcode values:
  - send 5A -> cmd_error pulses once, state stays IDLE;
  - then send 4C, 12, 4C, 62, ... -> row index 2; data bytes 4C and 62 are written at columns 0 and 1.
- Mid-row reset: assert reset after 50 data bytes, release, send 62, 10 -> all outputs at their reset values while reset is low; brightness=8'h10 afterwards; no further writes.
- Timeout (macro on, TIMEOUT_TICKS=15 for sim): send 4C, 05, 10 bytes, then stall 20 cycles ->
  - cmd_error pulses exactly once, at the 15th idle cycle;
  - state returns to IDLE;
  - a following 52 yields frame_swap.
- Back-to-back strobes: drive valid on consecutive cycles for a full row -> exactly 128 writes, no dropped or duplicated addresses.
